image_mean_filter_3x3: RTL

Streaming 3×3 mean (box) filter for 24-bit RGB video. It sits directly downstream of the three-line buffer stage and consumes its row-aligned previous/current/next pixel triplets. It forms the horizontal 3-tap window, zero-pads the left and right image borders, and emits one filtered pixel per input pixel in raster order. Vertical padding is already applied upstream.

---
 rtl/image_mean_filter_3x3.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/image_mean_filter_3x3.sv
// Streaming 3x3 box filter for 24-bit RGB: horizontal 3-tap window over pre-summed columns, zero-padded left/right borders.
// Optional `MEAN_FILTER_ROUND_EN selects round-to-nearest instead of truncating division by 9.
module image_mean_filter_3x3 (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] img_width,
   input  logic [9:0]  img_height,
   input  logic        valid_i,
   input  logic [23:0] prev_line_data_i,
   input  logic [23:0] cur_line_data_i,
   input  logic [23:0] next_line_data_i,
   output logic        valid_o,
   output logic [23:0] img_data_o,
   output logic        eof_o
);

   typedef logic [2:0][9:0]  col_t;
   typedef logic [2:0][11:0] tot_t;
   typedef logic [2:0][7:0]  pix_t;

   localparam logic [23:0] RECIP_9 = 24'd7282;
`ifdef MEAN_FILTER_ROUND_EN
   localparam logic [11:0] ROUND_BIAS = 12'd4;
`else
   localparam logic [11:0] ROUND_BIAS = 12'd0;
`endif

   logic [10:0] x_q, x_d;
   logic [9:0]  y_q, y_d;

   logic s1_valid_q, s1_valid_d;
   col_t s1_sum_q, s1_sum_d;
   logic s1_first_q, s1_first_d;
   logic s1_second_q, s1_second_d;
   logic s1_last_q, s1_last_d;
   logic s1_last_line_q, s1_last_line_d;

   col_t h1_q, h1_d;
   col_t h2_q, h2_d;
   logic flush_q, flush_d;
   logic flush_eof_q, flush_eof_d;
   logic flush_left_zero_q, flush_left_zero_d;

   logic win_valid_q, win_valid_d;
   col_t win_l_q, win_l_d;
   col_t win_c_q, win_c_d;
   col_t win_r_q, win_r_d;
   logic win_eof_q, win_eof_d;

   logic tot_valid_q, tot_valid_d;
   tot_t tot_q, tot_d;
   logic tot_eof_q, tot_eof_d;

   logic quo_valid_q, quo_valid_d;
   pix_t quo_q, quo_d;
   logic quo_eof_q, quo_eof_d;

   logic out_valid_q, out_valid_d;
   pix_t out_data_q, out_data_d;
   logic out_eof_q, out_eof_d;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (valid_i) begin
         if (x_q >= img_width - 11'd1) begin
            x_d = '0;
            if (y_q >= img_height - 10'd1) begin
               y_d = '0;
            end else begin
               y_d = y_q + 10'd1;
            end
         end else begin
            x_d = x_q + 11'd1;
         end
      end
   end

   // Column position is reduced to the few border flags the window stage needs.
   always_comb begin
      s1_valid_d     = valid_i;
      s1_sum_d       = s1_sum_q;
      s1_first_d     = s1_first_q;
      s1_second_d    = s1_second_q;
      s1_last_d      = s1_last_q;
      s1_last_line_d = s1_last_line_q;
      if (valid_i) begin
         for (int ch = 0; ch < 3; ch++) begin
            s1_sum_d[ch] = 10'(prev_line_data_i[ch*8 +: 8])
                         + 10'(cur_line_data_i[ch*8 +: 8])
                         + 10'(next_line_data_i[ch*8 +: 8]);
         end
         s1_first_d     = (x_q == 11'd0);
         s1_second_d    = (x_q == 11'd1);
         s1_last_d      = (x_q >= img_width - 11'd1);
         s1_last_line_d = (y_q >= img_height - 10'd1);
      end
   end

   // A new column x+1 releases the window centred on x; the line's last column is released by the flush one cycle later.
   always_comb begin
      h1_d              = h1_q;
      h2_d              = h2_q;
      flush_d           = s1_valid_q && s1_last_q;
      flush_eof_d       = s1_valid_q && s1_last_q && s1_last_line_q;
      flush_left_zero_d = s1_first_q;
      win_valid_d       = 1'b0;
      win_l_d           = win_l_q;
      win_c_d           = win_c_q;
      win_r_d           = win_r_q;
      win_eof_d         = 1'b0;
      if (s1_valid_q) begin
         h1_d = s1_sum_q;
         h2_d = h1_q;
      end
      if (flush_q) begin
         win_valid_d = 1'b1;
         win_l_d     = flush_left_zero_q ? '0 : h2_q;
         win_c_d     = h1_q;
         win_r_d     = '0;
         win_eof_d   = flush_eof_q;
      end else if (s1_valid_q && !s1_first_q) begin
         win_valid_d = 1'b1;
         win_l_d     = s1_second_q ? '0 : h2_q;
         win_c_d     = h1_q;
         win_r_d     = s1_sum_q;
      end
   end

   always_comb begin
      tot_valid_d = win_valid_q;
      tot_eof_d   = win_eof_q;
      tot_d       = tot_q;
      if (win_valid_q) begin
         for (int ch = 0; ch < 3; ch++) begin
            tot_d[ch] = 12'(win_l_q[ch]) + 12'(win_c_q[ch]) + 12'(win_r_q[ch]);
         end
      end
   end

   // Reciprocal multiply is exact floor(t/9) up to t=2299, which covers the biased maximum.
   always_comb begin
      quo_valid_d = tot_valid_q;
      quo_eof_d   = tot_eof_q;
      quo_d       = quo_q;
      if (tot_valid_q) begin
         for (int ch = 0; ch < 3; ch++) begin
            quo_d[ch] = 8'(({12'd0, tot_q[ch] + ROUND_BIAS} * RECIP_9) >> 16);
         end
      end
   end

   always_comb begin
      out_valid_d = quo_valid_q;
      out_eof_d   = quo_valid_q && quo_eof_q;
      out_data_d  = quo_valid_q ? quo_q : out_data_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_q               <= '0;
         y_q               <= '0;
         s1_valid_q        <= 1'b0;
         s1_sum_q          <= '0;
         s1_first_q        <= 1'b0;
         s1_second_q       <= 1'b0;
         s1_last_q         <= 1'b0;
         s1_last_line_q    <= 1'b0;
         h1_q              <= '0;
         h2_q              <= '0;
         flush_q           <= 1'b0;
         flush_eof_q       <= 1'b0;
         flush_left_zero_q <= 1'b0;
         win_valid_q       <= 1'b0;
         win_l_q           <= '0;
         win_c_q           <= '0;
         win_r_q           <= '0;
         win_eof_q         <= 1'b0;
         tot_valid_q       <= 1'b0;
         tot_q             <= '0;
         tot_eof_q         <= 1'b0;
         quo_valid_q       <= 1'b0;
         quo_q             <= '0;
         quo_eof_q         <= 1'b0;
         out_valid_q       <= 1'b0;
         out_data_q        <= '0;
         out_eof_q         <= 1'b0;
      end else begin
         x_q               <= x_d;
         y_q               <= y_d;
         s1_valid_q        <= s1_valid_d;
         s1_sum_q          <= s1_sum_d;
         s1_first_q        <= s1_first_d;
         s1_second_q       <= s1_second_d;
         s1_last_q         <= s1_last_d;
         s1_last_line_q    <= s1_last_line_d;
         h1_q              <= h1_d;
         h2_q              <= h2_d;
         flush_q           <= flush_d;
         flush_eof_q       <= flush_eof_d;
         flush_left_zero_q <= flush_left_zero_d;
         win_valid_q       <= win_valid_d;
         win_l_q           <= win_l_d;
         win_c_q           <= win_c_d;
         win_r_q           <= win_r_d;
         win_eof_q         <= win_eof_d;
         tot_valid_q       <= tot_valid_d;
         tot_q             <= tot_d;
         tot_eof_q         <= tot_eof_d;
         quo_valid_q       <= quo_valid_d;
         quo_q             <= quo_d;
         quo_eof_q         <= quo_eof_d;
         out_valid_q       <= out_valid_d;
         out_data_q        <= out_data_d;
         out_eof_q         <= out_eof_d;
      end
   end

   assign valid_o    = out_valid_q;
   assign img_data_o = out_data_q;
   assign eof_o      = out_eof_q;

endmodule
